reg_file: RTL
=============

Name: reg_file

Overview:
- Architectural register file with per-register rename tags, downstream of the reorder buffer's commit port and read by the instruction unit at issue.
- Holds 32 committed values plus, for each register, "pending" status and the ROB index of the youngest in-flight writer.
- Issue supplies source operands as either a ready value or a ROB tag to wait on.
- Commit writes values and retires tags; misprediction clear drops all tags.

Parameters:
- REG_NUM, 32, number of architectural registers; x0 is hardwired to zero.
- ROB_INDEX_BIT, 4, width of ROB index tags; must match the ROB.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  synchronous active-high reset.
- rdy_in  input  1  global ready; low freezes all state.
- clear_in  input  1  misprediction flush from ROB.
- issue_req  input  1  an instruction with a destination is issuing this cycle.
- issue_rd  input  5  destination register of the issuing instruction.
- issue_rob_id  input  ROB_INDEX_BIT  ROB slot allocated to the issuing instruction.
- rs1_in  input  5  source register 1 index.
- rs2_in  input  5  source register 2 index.
- commit_rd  input  5  committed destination; 0 = no write.
- commit_val  input  32  committed value.
- commit_rob_id  input  ROB_INDEX_BIT  ROB index of the committing instruction.
- rs1_val  output  32  value of rs1 (valid when rs1_dep=0).
- rs1_dep  output  1  rs1 waits on an in-flight writer.
- rs1_rob_id  output  ROB_INDEX_BIT  tag to wait on for rs1.
- rs2_val, rs2_dep, rs2_rob_id  output  32/1/ROB_INDEX_BIT  same for rs2.

Behaviour:
- State: val[0..31] (32b), busy[0..31], tag[0..31].
- Reset (rst_in=1 at posedge): all val=0, busy=0, tag=0.
  - Outputs are combinational from state, so after reset they read val=0, dep=0, rob_id=0.
  - Reset has priority over everything; a reset mid-stream discards the same-cycle issue and commit.
- rdy_in=0 (and no reset): no state change.
- Read ports: combinational, zero latency.
  - They reflect state before this cycle's issue update, so an instruction whose rd equals its rs sees the previous writer.
  - rs=0: always val=0, dep=0, rob_id=0.
- Commit (commit_rd!=0):
  - val[commit_rd] <= commit_val unconditionally.
  - busy is cleared only if busy[commit_rd] && tag[commit_rd]==commit_rob_id; a younger writer's tag survives.
- Issue (issue_req && issue_rd!=0 && !clear_in): busy[issue_rd] <= 1, tag[issue_rd] <= issue_rob_id.
- Issue and commit to the same register in the same cycle: the value write happens and the issue tag/busy wins, so busy stays 1 with the new tag.
- Issue/commit with rd=0: ignored; x0 never written or tagged.
- clear_in=1:
  - All busy <= 0 and tags <= 0; issue ignored.
  - A concurrent commit value write is still performed, since writes of already-committed values are idempotent.
  - Values are otherwise preserved.
- Tag width wrap: tags are plain ROB indices (0..2^ROB_INDEX_BIT-1). Reuse of an index is safe because the ROB retires a slot before reallocating it.

Optional Feature:
- RF_COMMIT_BYPASS_EN defined: a read of register r with commit_rd==r, busy[r], and tag[r]==commit_rob_id in the same cycle returns val=commit_val, dep=0. If the tag does not match, the read still returns dep=1 with the current tag.
- Not defined: reads return registered state only, so in the commit cycle they give dep=1 with the old tag. The consumer must capture the value from the ROB's commit broadcast.

Test Plan:
- Reset, then read rs1=5, rs2=0 -> rs1_val=0, rs1_dep=0; rs2 all zeros.
- Issue rd=3, rob_id=2; next cycle read rs1=3 -> dep=1, rob_id=2. Commit rd=3, rob_id=2, val=0x1234; next cycle -> dep=0, val=0x1234.
- Issue rd=4 with tag 1, then rd=4 with tag 5; commit rd=4, tag 1, val=7 -> rs1=4 reads dep=1, rob_id=5; val[4]=7 internally. Commit tag 5, val=9 -> dep=0, val=9.
- Same cycle: issue rd=6 tag 3 and commit rd=6 tag 0 (busy with tag 0), val=0xAA -> next cycle dep=1, rob_id=3. Separately, issue rd=0 -> x0 reads 0, dep=0.
- Tags set on x1, x2, x7; assert clear_in with commit rd=1, val=0x55 -> next cycle all dep=0, x1=0x55; a same-cycle issue rd=9 leaves x9 not busy.
- With RF_COMMIT_BYPASS_EN: x8 busy tag 4, commit rd=8, tag 4, val=0xBEEF while rs2=8 -> same-cycle rs2_val=0xBEEF, rs2_dep=0. Without the macro -> rs2_dep=1, rs2_rob_id=4.

Source files
------------

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags (busy + youngest ROB writer).
// Optional macro RF_COMMIT_BYPASS_EN forwards a matching same-cycle commit to the read ports.
module reg_file #(
  parameter int REG_NUM       = 32,
  parameter int ROB_INDEX_BIT = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clear_in,
  input  logic                     issue_req,
  input  logic [4:0]               issue_rd,
  input  logic [ROB_INDEX_BIT-1:0] issue_rob_id,
  input  logic [4:0]               rs1_in,
  input  logic [4:0]               rs2_in,
  input  logic [4:0]               commit_rd,
  input  logic [31:0]              commit_val,
  input  logic [ROB_INDEX_BIT-1:0] commit_rob_id,
  output logic [31:0]              rs1_val,
  output logic                     rs1_dep,
  output logic [ROB_INDEX_BIT-1:0] rs1_rob_id,
  output logic [31:0]              rs2_val,
  output logic                     rs2_dep,
  output logic [ROB_INDEX_BIT-1:0] rs2_rob_id
);

  logic [31:0]              val_reg  [REG_NUM];
  logic                     busy_reg [REG_NUM];
  logic [ROB_INDEX_BIT-1:0] tag_reg  [REG_NUM];

  genvar gi;

  // x0 shares the update logic but its write enables are tied off, so it stays at its reset zero.
  generate
    for (gi = 0; gi < REG_NUM; gi++) begin : g_reg
      logic commit_hit;
      logic issue_hit;
      logic retire_hit;

      assign commit_hit = (gi != 0) && (commit_rd == 5'(gi));
      assign issue_hit  = (gi != 0) && issue_req && (issue_rd == 5'(gi));
      assign retire_hit = commit_hit && busy_reg[gi] && (tag_reg[gi] == commit_rob_id);

      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          val_reg[gi]  <= '0;
          busy_reg[gi] <= 1'b0;
          tag_reg[gi]  <= '0;
        end else if (rdy_in) begin
          if (commit_hit)
            val_reg[gi] <= commit_val;
          if (clear_in) begin
            busy_reg[gi] <= 1'b0;
            tag_reg[gi]  <= '0;
          end else if (issue_hit) begin
            // A new writer overrides any same-cycle retirement of the old one.
            busy_reg[gi] <= 1'b1;
            tag_reg[gi]  <= issue_rob_id;
          end else if (retire_hit) begin
            busy_reg[gi] <= 1'b0;
          end
        end
      end
    end
  endgenerate

  logic [4:0]               rd_idx  [2];
  logic [31:0]              rd_val  [2];
  logic                     rd_dep  [2];
  logic [ROB_INDEX_BIT-1:0] rd_tag  [2];

  assign rd_idx[0] = rs1_in;
  assign rd_idx[1] = rs2_in;

  // Reads see pre-update state, so an instruction reading its own rd sees the previous writer.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_read
      always_comb begin
        rd_val[gi] = '0;
        rd_dep[gi] = 1'b0;
        rd_tag[gi] = '0;
        if (rd_idx[gi] != 5'd0) begin
          rd_val[gi] = val_reg[rd_idx[gi]];
          rd_dep[gi] = busy_reg[rd_idx[gi]];
          rd_tag[gi] = tag_reg[rd_idx[gi]];
`ifdef RF_COMMIT_BYPASS_EN
          if (rdy_in && !rst_in && (commit_rd == rd_idx[gi]) && busy_reg[rd_idx[gi]]
              && (tag_reg[rd_idx[gi]] == commit_rob_id)) begin
            rd_val[gi] = commit_val;
            rd_dep[gi] = 1'b0;
            rd_tag[gi] = '0;
          end
`endif
        end
      end
    end
  endgenerate

  assign rs1_val    = rd_val[0];
  assign rs1_dep    = rd_dep[0];
  assign rs1_rob_id = rd_tag[0];
  assign rs2_val    = rd_val[1];
  assign rs2_dep    = rd_dep[1];
  assign rs2_rob_id = rd_tag[1];

endmodule
